// File: rtl/tdc_hw_window_stats.sv
// Window statistics (min/max/sum/mean) over 2^LOG2_N TDC Hamming-weight samples.
// Optional macro TDC_STATS_SYNC_EN: synchronise hw_valid and take one sample per rising edge.
module tdc_hw_window_stats #(
  parameter int HW_W   = 7,
  parameter int LOG2_N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [HW_W-1:0]          hw_in,
  input  logic                     hw_valid,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     res_valid,
  output logic [HW_W-1:0]          res_min,
  output logic [HW_W-1:0]          res_max,
  output logic [HW_W+LOG2_N-1:0]   res_sum,
  output logic [HW_W-1:0]          res_mean,
  output logic                     overrun
);

  localparam int SW = HW_W + LOG2_N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [LOG2_N:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [LOG2_N:0] ONE   = {{LOG2_N{1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [SW-1:0]    r_acc;
  logic [HW_W-1:0]  r_min;
  logic [HW_W-1:0]  r_max;
  logic [LOG2_N:0]  r_cnt;
  logic [HW_W-1:0]  r_res_min;
  logic [HW_W-1:0]  r_res_max;
  logic [SW-1:0]    r_res_sum;
  logic [HW_W-1:0]  r_res_mean;
  logic             r_overrun;

  logic             w_smp_v;
  logic [HW_W-1:0]  w_smp_hw;
  logic [SW-1:0]    w_sum;
  logic [HW_W-1:0]  w_min;
  logic [HW_W-1:0]  w_max;
  logic [LOG2_N:0]  w_cnt;
  logic             w_last;

`ifdef TDC_STATS_SYNC_EN
  logic             r_vs1;
  logic             r_vs2;
  logic             r_vs3;
  logic             r_edge;
  logic [HW_W-1:0]  r_hw1;
  logic [HW_W-1:0]  r_hw2;
  logic [HW_W-1:0]  r_hw3;

  // Two-flop synchroniser, rising-edge detect, and a matching data pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs1  <= 1'b0;
      r_vs2  <= 1'b0;
      r_vs3  <= 1'b0;
      r_edge <= 1'b0;
      r_hw1  <= '0;
      r_hw2  <= '0;
      r_hw3  <= '0;
    end else begin
      r_vs1  <= hw_valid;
      r_vs2  <= r_vs1;
      r_vs3  <= r_vs2;
      r_edge <= r_vs2 & ~r_vs3;
      r_hw1  <= hw_in;
      r_hw2  <= r_hw1;
      r_hw3  <= r_hw2;
    end
  end

  assign w_smp_v  = r_edge;
  assign w_smp_hw = r_hw3;
`else
  assign w_smp_v  = hw_valid;
  assign w_smp_hw = hw_in;
`endif

  assign w_sum  = r_acc + SW'(w_smp_hw);
  assign w_min  = (w_smp_hw < r_min) ? w_smp_hw : r_min;
  assign w_max  = (w_smp_hw > r_max) ? w_smp_hw : r_max;
  assign w_cnt  = r_cnt + ONE;
  assign w_last = (w_cnt == N_CNT);

  // Window FSM: accumulate, latch the result, hold until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_cnt      <= '0;
      r_res_min  <= '0;
      r_res_max  <= '0;
      r_res_sum  <= '0;
      r_res_mean <= '0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ACCUM;
            r_acc     <= '0;
            r_min     <= '1;
            r_max     <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_smp_v) begin
            r_acc <= w_sum;
            r_min <= w_min;
            r_max <= w_max;
            r_cnt <= w_cnt;
            if (w_last) begin
              r_state    <= S_HOLD;
              r_res_min  <= w_min;
              r_res_max  <= w_max;
              r_res_sum  <= w_sum;
              r_res_mean <= w_sum[SW-1:LOG2_N];
            end
          end
        end
        S_HOLD: begin
          if (w_smp_v) begin
            r_overrun <= 1'b1;
          end
          if (res_ready) begin
            if (start) begin
              r_state   <= S_ACCUM;
              r_acc     <= '0;
              r_min     <= '1;
              r_max     <= '0;
              r_cnt     <= '0;
              r_overrun <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_ACCUM);
  assign res_valid = (r_state == S_HOLD);
  assign res_min   = r_res_min;
  assign res_max   = r_res_max;
  assign res_sum   = r_res_sum;
  assign res_mean  = r_res_mean;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_tdc_hw_window_stats.sv
// Scoreboard bench for tdc_hw_window_stats (default build).
// Expected window results are computed from recorded samples and popped by a monitor.
module tb_tdc_hw_window_stats;

  localparam int HW_W   = 7;
  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;

  typedef struct {
    int mn;
    int mx;
    int sum;
    int mean;
  } res_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [HW_W-1:0]        hw_in = '0;
  logic                   hw_valid = 1'b0;
  logic                   res_ready = 1'b0;
  logic                   busy;
  logic                   res_valid;
  logic [HW_W-1:0]        res_min;
  logic [HW_W-1:0]        res_max;
  logic [HW_W+LOG2_N-1:0] res_sum;
  logic [HW_W-1:0]        res_mean;
  logic                   overrun;

  int   checks = 0;
  int   errors = 0;
  int   cur[$];
  res_t exp_q[$];
  res_t last;
  logic mon_prev = 1'b0;

  tdc_hw_window_stats #(.HW_W(HW_W), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hw_in(hw_in), .hw_valid(hw_valid), .res_ready(res_ready),
    .busy(busy), .res_valid(res_valid), .res_min(res_min),
    .res_max(res_max), .res_sum(res_sum), .res_mean(res_mean),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: statistics of the recorded window computed directly.
  function automatic res_t model(input int s[$]);
    res_t r;
    r.mn = s[0];
    r.mx = s[0];
    r.sum = 0;
    foreach (s[i]) begin
      if (s[i] < r.mn) r.mn = s[i];
      if (s[i] > r.mx) r.mx = s[i];
      r.sum += s[i];
    end
    r.mean = r.sum / N;
    return r;
  endfunction

  // mode 0: constant base, 1: ramp 0.., 2: random with random gaps
  task automatic feed(input int n, input int mode, input int base,
                      input bit gaps);
    int v;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) v = base;
      else if (mode == 1) v = i;
      else v = int'($urandom_range(0, 127));
      hw_in = HW_W'(v);
      hw_valid = 1'b1;
      cur.push_back(v);
      cyc();
      hw_valid = 1'b0;
      if (i < n - 1 && (gaps || (mode == 2 && $urandom_range(0, 1) == 1))) begin
        hw_in = HW_W'($urandom_range(0, 127));
        cyc();
      end
    end
  endtask

  task automatic close_window(input string name);
    res_t r;
    r = model(cur);
    exp_q.push_back(r);
    last = r;
    cur.delete();
    check({name, "_latency_valid"}, int'(res_valid), 1);
    check({name, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic check_res_kept(input string name);
    check({name, "_min"}, int'(res_min), last.mn);
    check({name, "_max"}, int'(res_max), last.mx);
    check({name, "_sum"}, int'(res_sum), last.sum);
    check({name, "_mean"}, int'(res_mean), last.mean);
  endtask

  // Monitor: on each newly presented result, pop and compare.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      mon_prev = 1'b0;
    end else begin
      if (res_valid && !mon_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_min", int'(res_min), e.mn);
          check("sb_max", int'(res_max), e.mx);
          check("sb_sum", int'(res_sum), e.sum);
          check("sb_mean", int'(res_mean), e.mean);
        end
      end
      mon_prev = res_valid;
    end
  end

  initial begin
    last = '{0, 0, 0, 0};
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check_res_kept("rst");

    hw_valid = 1'b1;
    hw_in = 7'd9;
    repeat (3) cyc();
    hw_valid = 1'b0;
    check("idle_ignore_busy", int'(busy), 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    check("const_busy", int'(busy), 1);
    feed(N, 0, 5, 1'b0);
    close_window("const");
    check("const_sum80", int'(res_sum), 80);

    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) begin
        hw_valid = 1'b1;
        hw_in = HW_W'($urandom_range(0, 127));
      end
      cyc();
      hw_valid = 1'b0;
    end
    check("bp_overrun", int'(overrun), 1);
    check("bp_valid_held", int'(res_valid), 1);
    check_res_kept("bp_stable");
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    check("bp_valid_drop", int'(res_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_clr_overrun", int'(overrun), 0);

    feed(N, 1, 0, 1'b1);
    close_window("ramp");
    check("ramp_mean7", int'(res_mean), 7);

    res_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_valid_drop", int'(res_valid), 0);
    feed(N, 0, 64, 1'b0);
    close_window("b2b");
    check("b2b_sum1024", int'(res_sum), 1024);
    cyc();
    check("b2b_consumed", int'(res_valid), 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    feed(7, 2, 0, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cur.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(res_valid), 0);
    check_res_kept("abort_keep");

    start = 1'b1;
    cyc();
    start = 1'b0;
    feed(N - 1, 2, 0, 1'b0);
    hw_in = 7'd1;
    hw_valid = 1'b1;
    abort = 1'b1;
    cyc();
    hw_valid = 1'b0;
    abort = 1'b0;
    cur.delete();
    check("abort16_busy", int'(busy), 0);
    check("abort16_valid", int'(res_valid), 0);
    check_res_kept("abort16_keep");
    repeat (3) cyc();

    start = 1'b1;
    cyc();
    start = 1'b0;
    feed(9, 2, 0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cur.delete();
    last = '{0, 0, 0, 0};
    check("mrst_busy", int'(busy), 0);
    check("mrst_valid", int'(res_valid), 0);
    check("mrst_overrun", int'(overrun), 0);
    check_res_kept("mrst_zero");
    start = 1'b1;
    cyc();
    start = 1'b0;
    feed(N, 0, 3, 1'b0);
    close_window("post_rst");
    check("post_rst_sum48", int'(res_sum), 48);
    cyc();

    for (int w = 0; w < 6; w++) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
      feed(N, 2, 0, 1'b0);
      close_window("rand");
      repeat ($urandom_range(1, 3)) cyc();
    end

    res_ready = 1'b0;
    repeat (4) cyc();
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
